axi_lite_master_cmd: RTL

Parametrised AXI4-Lite master that turns a single-entry command interface (read or write, any address/data width, byte strobes) into compliant AXI4-Lite transactions and reports completion, read data, response code and timeout. It replaces the fixed 4-bit-address, write-only trigger master, and sits between local control logic and the AXI4-Lite interconnect. One transaction is outstanding at a time.

---
 rtl/axi_lite_master_cmd_if.sv | 42 ++++
 rtl/axi_lite_master_cmd.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_cmd_if.sv
// AXI4-Lite bus bundle between the command master and the interconnect.
// The master modport drives AW/W/AR and the B/R readies; the slave modport mirrors it.
interface axi_lite_master_cmd_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI4-Lite master: turns one read/write command into AW/W/B or AR/R
// traffic and reports a registered completion pulse with response, read data and timeout.
module axi_lite_master_cmd #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                txn_done,
    output logic                txn_error,
    output logic                txn_timeout,
    output logic [1:0]          txn_resp,
    output logic [DATA_W-1:0]   txn_rdata,
    axi_lite_master_cmd_if.master m_axi
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RA   = 3'd3,
        ST_RD   = 3'd4
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic [ADDR_W-1:0]   r_awaddr,  w_awaddr_nxt;
    logic [DATA_W-1:0]   r_wdata,   w_wdata_nxt;
    logic [DATA_W/8-1:0] r_wstrb,   w_wstrb_nxt;
    logic [ADDR_W-1:0]   r_araddr,  w_araddr_nxt;
    logic                r_awvalid, w_awvalid_nxt;
    logic                r_wvalid,  w_wvalid_nxt;
    logic                r_bready,  w_bready_nxt;
    logic                r_arvalid, w_arvalid_nxt;
    logic                r_rready,  w_rready_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_error,   w_error_nxt;
    logic                r_tmo,     w_tmo_nxt;
    logic [1:0]          r_resp,    w_resp_nxt;
    logic [DATA_W-1:0]   r_rdata,   w_rdata_nxt;
    logic                w_hit;
    logic                w_abort;
    logic                w_aw_ok;
    logic                w_w_ok;

    assign cmd_ready      = (r_state == ST_IDLE) && aresetn;
    assign txn_done       = r_done;
    assign txn_error      = r_error;
    assign txn_timeout    = r_tmo;
    assign txn_resp       = r_resp;
    assign txn_rdata      = r_rdata;
    assign m_axi.awaddr   = r_awaddr;
    assign m_axi.awprot   = 3'b000;
    assign m_axi.awvalid  = r_awvalid;
    assign m_axi.wdata    = r_wdata;
    assign m_axi.wstrb    = r_wstrb;
    assign m_axi.wvalid   = r_wvalid;
    assign m_axi.bready   = r_bready;
    assign m_axi.araddr   = r_araddr;
    assign m_axi.arprot   = 3'b000;
    assign m_axi.arvalid  = r_arvalid;
    assign m_axi.rready   = r_rready;

    // Timeout fires on the edge where the busy-cycle count would reach TIMEOUT.
    assign w_hit   = (TIMEOUT != 0) && (r_state != ST_IDLE) && (r_cnt == TO_LAST);
    // A channel counts as done once its valid has dropped or is handshaking this edge.
    assign w_aw_ok = !r_awvalid || m_axi.awready;
    assign w_w_ok  = !r_wvalid  || m_axi.wready;

    // Next-state and next-register values for the transaction FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = (r_state == ST_IDLE) ? {CNT_W{1'b0}} : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_araddr_nxt  = r_araddr;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_done_nxt    = 1'b0;
        w_error_nxt   = r_error;
        w_tmo_nxt     = r_tmo;
        w_resp_nxt    = r_resp;
        w_rdata_nxt   = r_rdata;
        w_abort       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_we) begin
                        w_awaddr_nxt  = cmd_addr;
                        w_wdata_nxt   = cmd_wdata;
                        w_wstrb_nxt   = cmd_wstrb;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = ST_WR;
                    end else begin
                        w_araddr_nxt  = cmd_addr;
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = ST_RA;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                if (m_axi.awready) begin
                    w_awvalid_nxt = 1'b0;
                end else begin
                    w_awvalid_nxt = r_awvalid;
                end
                if (m_axi.wready) begin
                    w_wvalid_nxt = 1'b0;
                end else begin
                    w_wvalid_nxt = r_wvalid;
                end
                if (w_aw_ok && w_w_ok) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = ST_WB;
                end else begin
                    w_abort = w_hit;
                end
            end
            ST_WB: begin
                if (m_axi.bvalid) begin
                    w_bready_nxt = 1'b0;
                    w_resp_nxt   = m_axi.bresp;
                    w_error_nxt  = (m_axi.bresp != 2'b00);
                    w_tmo_nxt    = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_abort = w_hit;
                end
            end
            ST_RA: begin
                if (m_axi.arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RD;
                end else begin
                    w_abort = w_hit;
                end
            end
            ST_RD: begin
                if (m_axi.rvalid) begin
                    w_rready_nxt = 1'b0;
                    w_rdata_nxt  = m_axi.rdata;
                    w_resp_nxt   = m_axi.rresp;
                    w_error_nxt  = (m_axi.rresp != 2'b00);
                    w_tmo_nxt    = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_abort = w_hit;
                end
            end
            default: begin
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase

        if (w_abort) begin
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
            w_bready_nxt  = 1'b0;
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b0;
            w_done_nxt    = 1'b1;
            w_tmo_nxt     = 1'b1;
            w_error_nxt   = 1'b1;
            w_resp_nxt    = 2'b00;
            w_state_nxt   = ST_IDLE;
        end else begin
            w_tmo_nxt = w_tmo_nxt;
        end
    end

    // State and output registers; reset aborts any transaction without a completion pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_awaddr  <= {ADDR_W{1'b0}};
            r_wdata   <= {DATA_W{1'b0}};
            r_wstrb   <= {(DATA_W/8){1'b0}};
            r_araddr  <= {ADDR_W{1'b0}};
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_tmo     <= 1'b0;
            r_resp    <= 2'b00;
            r_rdata   <= {DATA_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_awaddr  <= w_awaddr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_araddr  <= w_araddr_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
            r_tmo     <= w_tmo_nxt;
            r_resp    <= w_resp_nxt;
            r_rdata   <= w_rdata_nxt;
        end
    end
endmodule
